uart_tx_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte-stream requesters.
- Each requester sends packets: a sequence of bytes ending with a byte flagged last. A granted requester keeps the transmitter until its last byte is sent, or until it stalls mid-packet past a timeout.
- Sits between client logic (command responders, status reporters) and the transmitter's send_req / d_in / tx_ready interface.

---
 rtl/uart_tx_arb_if.sv | 23 ++
 rtl/uart_tx_arb.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter handshake bundle for the UART transmit arbiter.
// The master side drives requests and transmitter status; the slave side is the arbiter.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_ready;
  logic                 send_req;
  logic [7:0]           d_in;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, send_req, d_in
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, send_req, d_in
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one UART transmitter from NUM_REQ byte streams.
// Latency: grant one cycle after req_valid in IDLE, send_req/d_in one cycle after acceptance.
// Backpressure: req_ready only in LOAD with tx_ready high; owner keeps the line until last byte or timeout.
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arb_if.slave       bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               pkt_done,
  output logic               timeout_err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] SEND      = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] cnt;
  logic             last_flag;

  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic             accept;
  logic             timeout_hit;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_data  = bus.req_data[8*i +: 8];
        sel_last  = bus.req_last[i];
      end
    end
  end

  // Search starts just past the previous owner so every waiting requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_idx;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (int'(last_idx) + k >= NUM_REQ)
        cand = IDX_W'(int'(last_idx) + k - NUM_REQ);
      else
        cand = IDX_W'(int'(last_idx) + k);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign accept        = (state == LOAD) && sel_valid && bus.tx_ready;
  assign timeout_hit   = (TIMEOUT != 0) && (state == LOAD) && !sel_valid && (cnt == TO_LAST);
  assign bus.req_ready = accept ? grant : '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      owner        <= '0;
      last_idx     <= IDX_W'(NUM_REQ - 1);
      cnt          <= '0;
      last_flag    <= 1'b0;
      bus.send_req <= 1'b0;
      bus.d_in     <= 8'h00;
      pkt_done     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      bus.send_req <= 1'b0;
      pkt_done     <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            grant <= NUM_REQ'(1) << pick;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            bus.d_in     <= sel_data;
            last_flag    <= sel_last;
            cnt          <= '0;
            bus.send_req <= 1'b1;
            state        <= SEND;
          end else if (!sel_valid) begin
            if (timeout_hit) begin
              timeout_err <= 1'b1;
              last_idx    <= owner;
              grant       <= '0;
              cnt         <= '0;
              state       <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        SEND: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (!bus.tx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_ready) begin
            if (last_flag) begin
              pkt_done <= 1'b1;
              last_idx <= owner;
              grant    <= '0;
              state    <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed packets, transmitter model, decoupled monitor.
module tb_uart_tx_arb;
  localparam int NR   = 4;
  localparam int BUSY = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(NR)) bus ();
  logic [NR-1:0] grant;
  logic          busy;
  logic          pkt_done;
  logic          timeout_err;

  uart_tx_arb #(.NUM_REQ(NR), .TIMEOUT(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant(grant),
    .busy(busy), .pkt_done(pkt_done), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event with no expected entry", name);
  endtask

  // Per-requester byte queues {last, data}; scoreboard queues of expected responses.
  logic [8:0]  rq[NR][$];
  logic [10:0] exp_q[$];
  int          done_q[$];
  int          to_q[$];

  logic        drv_valid[NR];
  logic [7:0]  drv_data[NR];
  logic        drv_last[NR];
  logic [NR-1:0] drv_rdy;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]      = drv_valid[i];
      bus.req_data[8*i +: 8] = drv_data[i];
      bus.req_last[i]       = drv_last[i];
    end
  end

  // Requester driver: holds head byte until req_ready was seen in the cycle.
  initial begin
    for (int i = 0; i < NR; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = 8'h00;
      drv_last[i]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      drv_rdy = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (drv_rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          drv_valid[i] = 1'b1;
          drv_data[i]  = rq[i][0][7:0];
          drv_last[i]  = rq[i][0][8];
        end else begin
          drv_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: goes busy for BUSY cycles after seeing send_req.
  int   bcnt = 0;
  logic tx_stall = 1'b0;
  logic sr_s;
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      sr_s = bus.send_req;
      @(posedge clk);
      #1;
      if (sr_s === 1'b1) bcnt = BUSY;
      else if (bcnt > 0) bcnt--;
      bus.tx_ready = !tx_stall && (bcnt == 0);
    end
  end

  function automatic int oh2idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Monitor: compares every DUT output event against the scoreboard.
  int          last_owner = 0;
  logic [10:0] mon_exp;
  logic [10:0] mon_act;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (grant != '0) last_owner = oh2idx(grant);
        if (bus.req_ready != '0)
          chk("ready_is_owner", 32'(bus.req_ready), 32'(grant));
        if (bus.send_req === 1'b1) begin
          chk("send_tx_ready", 32'(bus.tx_ready), 32'h1);
          if (exp_q.size() == 0) unexpected("send_req");
          else begin
            mon_exp = exp_q.pop_front();
            mon_act = {3'(last_owner), bus.d_in};
            chk("tx_owner_byte", 32'(mon_act), 32'(mon_exp));
          end
        end
        if (pkt_done === 1'b1) begin
          if (done_q.size() == 0) unexpected("pkt_done");
          else chk("pkt_done_owner", 32'(last_owner), 32'(done_q.pop_front()));
        end
        if (timeout_err === 1'b1) begin
          if (to_q.size() == 0) unexpected("timeout_err");
          else chk("timeout_owner", 32'(last_owner), 32'(to_q.pop_front()));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) rq[i].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || to_q.size() != 0 ||
            busy || !bus.tx_ready) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_drained"}, 32'(k < 2000), 32'h1);
  endtask

  task automatic wait_send(input string name);
    int k = 0;
    while (bus.send_req !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_send_seen"}, 32'(k < 200), 32'h1);
  endtask

  initial begin
    int   k;
    logic saw_a, saw_b, saw_c;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic saw_a, saw_b, saw_c;

    // Single requester, three-byte packet, with reset values and first-byte latency.
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_send_req", 32'(bus.send_req), 32'h0);
    chk("rst_d_in", 32'(bus.d_in), 32'h0);
    chk("rst_pkt_done", 32'(pkt_done), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    rq[0].push_back({1'b0, 8'hA1});
    rq[0].push_back({1'b0, 8'hA2});
    rq[0].push_back({1'b1, 8'hA3});
    exp_q.push_back({3'd0, 8'hA1});
    exp_q.push_back({3'd0, 8'hA2});
    exp_q.push_back({3'd0, 8'hA3});
    done_q.push_back(0);
    @(negedge clk);
    chk("lat_t_grant", 32'(grant), 32'h0);
    @(negedge clk);
    chk("lat_t1_grant", 32'(grant), 32'h1);
    chk("lat_t1_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("lat_t2_send", 32'(bus.send_req), 32'h1);
    chk("lat_t2_d_in", 32'(bus.d_in), 32'hA1);
    k = 0;
    while (pkt_done !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("single_done_seen", 32'(k < 500), 32'h1);
    chk("single_done_grant", 32'(grant), 32'h0);
    chk("single_done_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("single_done_pulse", 32'(pkt_done), 32'h0);
    drain("single");

    // Round-robin: all four valid with single-byte packets, requester 0 twice.
    do_reset();
    rq[0].push_back({1'b1, 8'hB0});
    rq[0].push_back({1'b1, 8'hB4});
    rq[1].push_back({1'b1, 8'hB1});
    rq[2].push_back({1'b1, 8'hB2});
    rq[3].push_back({1'b1, 8'hB3});
    exp_q.push_back({3'd0, 8'hB0});
    exp_q.push_back({3'd1, 8'hB1});
    exp_q.push_back({3'd2, 8'hB2});
    exp_q.push_back({3'd3, 8'hB3});
    exp_q.push_back({3'd0, 8'hB4});
    done_q.push_back(0);
    done_q.push_back(1);
    done_q.push_back(2);
    done_q.push_back(3);
    done_q.push_back(0);
    drain("rr");

    // Packet lock: requester 1 owns a 4-byte packet while requester 0 waits.
    do_reset();
    rq[1].push_back({1'b0, 8'hC0});
    rq[1].push_back({1'b0, 8'hC1});
    rq[1].push_back({1'b0, 8'hC2});
    rq[1].push_back({1'b1, 8'hC3});
    exp_q.push_back({3'd1, 8'hC0});
    exp_q.push_back({3'd1, 8'hC1});
    exp_q.push_back({3'd1, 8'hC2});
    exp_q.push_back({3'd1, 8'hC3});
    done_q.push_back(1);
    k = 0;
    while (grant !== 4'b0010 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("lock_grant1", 32'(grant), 32'h2);
    rq[0].push_back({1'b1, 8'hD0});
    exp_q.push_back({3'd0, 8'hD0});
    done_q.push_back(0);
    saw_a = 1'b0;
    k = 0;
    while (pkt_done !== 1'b1 && k < 1000) begin
      @(negedge clk);
      saw_a = saw_a | bus.req_ready[0];
      k++;
    end
    chk("lock_rdy0_held", 32'(saw_a), 32'h0);
    @(negedge clk);
    chk("lock_then_grant0", 32'(grant), 32'h1);
    drain("lock");

    // Timeout: requester 2 sends one non-last byte then drops valid.
    do_reset();
    rq[2].push_back({1'b0, 8'hE0});
    exp_q.push_back({3'd2, 8'hE0});
    to_q.push_back(2);
    wait_send("timeout");
    k = 0;
    while (timeout_err !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", 32'(k), 32'd32);
    chk("timeout_grant", 32'(grant), 32'h0);
    rq[0].push_back({1'b1, 8'hF0});
    rq[3].push_back({1'b1, 8'hF3});
    exp_q.push_back({3'd3, 8'hF3});
    exp_q.push_back({3'd0, 8'hF0});
    done_q.push_back(3);
    done_q.push_back(0);
    @(negedge clk);
    chk("timeout_pulse", 32'(timeout_err), 32'h0);
    drain("timeout");

    // Transmitter stall: valid owner in LOAD with tx_ready low for 50 cycles.
    do_reset();
    tx_stall = 1'b1;
    rq[0].push_back({1'b1, 8'h5A});
    exp_q.push_back({3'd0, 8'h5A});
    done_q.push_back(0);
    saw_a = 1'b0;
    saw_b = 1'b0;
    saw_c = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      saw_a = saw_a | bus.req_ready[0];
      saw_b = saw_b | bus.send_req;
      saw_c = saw_c | timeout_err;
    end
    chk("stall_grant", 32'(grant), 32'h1);
    chk("stall_no_ready", 32'(saw_a), 32'h0);
    chk("stall_no_send", 32'(saw_b), 32'h0);
    chk("stall_no_timeout", 32'(saw_c), 32'h0);
    tx_stall = 1'b0;
    drain("stall");

    // Reset in WAIT_DONE, then a new request must wait for the line to go idle.
    do_reset();
    rq[1].push_back({1'b0, 8'h71});
    rq[1].push_back({1'b1, 8'h72});
    exp_q.push_back({3'd1, 8'h71});
    wait_send("mid_rst");
    repeat (3) @(negedge clk);
    chk("mid_rst_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    rq[1].delete();
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_send", 32'(bus.send_req), 32'h0);
    rst = 1'b0;
    rq[2].push_back({1'b1, 8'h82});
    exp_q.push_back({3'd2, 8'h82});
    done_q.push_back(2);
    saw_a = 1'b0;
    k = 0;
    while (bus.tx_ready !== 1'b1 && k < 100) begin
      saw_a = saw_a | (bus.req_ready != '0);
      @(negedge clk);
      k++;
    end
    chk("mid_rst_no_early_ready", 32'(saw_a), 32'h0);
    drain("mid_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
